// File: rtl/eu_operand_collector.sv
// Execution-unit operand collector: gathers NUM_RX source operands over independent RX channels,
// hands them to the ALU and parks results in a small address-searchable result buffer.
module eu_operand_collector #(
  parameter int NUM_RX    = 2,
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 8,
  parameter int OPC_W     = 4,
  parameter int RES_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     instr_valid_i,
  input  logic [OPC_W-1:0]         instr_opc_i,
  input  logic [NUM_RX*ADDR_W-1:0] instr_src_addr_i,
  input  logic [ADDR_W-1:0]        instr_dst_addr_i,
  output logic                     ready_for_next_instr_o,
  output logic [NUM_RX-1:0]        rx_req_valid_o,
  output logic [NUM_RX*ADDR_W-1:0] rx_req_addr_o,
  input  logic [NUM_RX*DATA_W-1:0] rx_data_i,
  input  logic [NUM_RX-1:0]        rx_success_i,
  output logic                     alu_valid_o,
  output logic [OPC_W-1:0]         alu_opc_o,
  output logic [NUM_RX*DATA_W-1:0] alu_operands_o,
  input  logic                     alu_done_i,
  input  logic [DATA_W-1:0]        alu_result_i,
  input  logic                     icon_tx_req_valid_i,
  input  logic [ADDR_W-1:0]        icon_tx_addr_i,
  output logic [DATA_W-1:0]        icon_tx_data_o,
  output logic                     icon_tx_success_o
);

  localparam int IDX_W = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_WRITE = 2'd3
  } state_e;

  state_e                   state_q, state_d;
  logic [OPC_W-1:0]         opc_q, opc_d;
  logic [NUM_RX*ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0]        dst_q, dst_d;
  logic [NUM_RX-1:0]        got_q, got_d;
  logic [NUM_RX*DATA_W-1:0] ops_q, ops_d;
  logic [DATA_W-1:0]        res_q, res_d;
  logic [RES_DEPTH-1:0]     bv_q, bv_d;
  logic [ADDR_W-1:0]        ba_q [RES_DEPTH];
  logic [ADDR_W-1:0]        ba_d [RES_DEPTH];
  logic [DATA_W-1:0]        bd_q [RES_DEPTH];
  logic [DATA_W-1:0]        bd_d [RES_DEPTH];

  logic [RES_DEPTH-1:0]     match_s;
  logic                     hit_s;
  logic                     full_s;
  logic [IDX_W-1:0]         hit_idx_s;
  logic [IDX_W-1:0]         wr_idx_s;

  // Scanning downward leaves the lowest matching / lowest free index in place.
  always_comb begin
    match_s   = '0;
    hit_idx_s = '0;
    wr_idx_s  = '0;
    for (int i = RES_DEPTH - 1; i >= 0; i--) begin
      match_s[i] = icon_tx_req_valid_i && bv_q[i] && (ba_q[i] == icon_tx_addr_i);
      hit_idx_s  = match_s[i] ? IDX_W'(i) : hit_idx_s;
      wr_idx_s   = !bv_q[i] ? IDX_W'(i) : wr_idx_s;
    end
    hit_s             = |match_s;
    full_s            = &bv_q;
    icon_tx_success_o = hit_s;
    icon_tx_data_o    = hit_s ? bd_q[hit_idx_s] : '0;
  end

  always_comb begin
    state_d = state_q;
    opc_d   = opc_q;
    src_d   = src_q;
    dst_d   = dst_q;
    got_d   = got_q;
    ops_d   = ops_q;
    res_d   = res_q;
    bv_d    = bv_q;
    ba_d    = ba_q;
    bd_d    = bd_q;
    ready_for_next_instr_o = 1'b0;
    rx_req_valid_o         = '0;
    rx_req_addr_o          = '0;
    alu_valid_o            = 1'b0;
    alu_opc_o              = '0;
    alu_operands_o         = '0;

    // A read hit can never target the slot being written (that slot is free in bv_q).
    if (hit_s) begin
      bv_d[hit_idx_s] = 1'b0;
    end else begin
      bv_d = bv_q;
    end

    case (state_q)
      ST_IDLE: begin
        ready_for_next_instr_o = ~full_s;
        if (instr_valid_i && !full_s) begin
          opc_d = instr_opc_i;
          src_d = instr_src_addr_i;
          dst_d = instr_dst_addr_i;
          ops_d = '0;
          for (int i = 0; i < NUM_RX; i++) begin
            got_d[i] = (instr_src_addr_i[i*ADDR_W +: ADDR_W] == '0);
          end
          state_d = ST_FETCH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH: begin
        for (int i = 0; i < NUM_RX; i++) begin
          rx_req_valid_o[i] = ~got_q[i];
          rx_req_addr_o[i*ADDR_W +: ADDR_W] = got_q[i] ? '0 : src_q[i*ADDR_W +: ADDR_W];
          if (rx_success_i[i] && !got_q[i]) begin
            got_d[i] = 1'b1;
            ops_d[i*DATA_W +: DATA_W] = rx_data_i[i*DATA_W +: DATA_W];
          end else begin
            got_d[i] = got_q[i];
          end
        end
        state_d = (&got_d) ? ST_EXEC : ST_FETCH;
      end
      ST_EXEC: begin
        alu_valid_o    = 1'b1;
        alu_opc_o      = opc_q;
        alu_operands_o = ops_q;
        if (alu_done_i) begin
          res_d   = alu_result_i;
          state_d = ST_WRITE;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_WRITE: begin
        bv_d[wr_idx_s] = 1'b1;
        ba_d[wr_idx_s] = dst_q;
        bd_d[wr_idx_s] = res_q;
        state_d        = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      opc_q   <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      got_q   <= '0;
      ops_q   <= '0;
      res_q   <= '0;
      bv_q    <= '0;
      for (int i = 0; i < RES_DEPTH; i++) begin
        ba_q[i] <= '0;
        bd_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      opc_q   <= opc_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      got_q   <= got_d;
      ops_q   <= ops_d;
      res_q   <= res_d;
      bv_q    <= bv_d;
      ba_q    <= ba_d;
      bd_q    <= bd_d;
    end
  end

endmodule

// File: tb/tb_eu_operand_collector.sv
// Randomized bench for eu_operand_collector: a transaction-level reference model predicts
// handshakes and buffer contents; a negedge monitor pops the expectations and compares.
module tb_eu_operand_collector;

  localparam int NRX = 2;
  localparam int DW  = 16;
  localparam int AW  = 8;
  localparam int OW  = 4;
  localparam int RD  = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              instr_valid_i;
  logic [OW-1:0]     instr_opc_i;
  logic [NRX*AW-1:0] instr_src_addr_i;
  logic [AW-1:0]     instr_dst_addr_i;
  logic              ready_for_next_instr_o;
  logic [NRX-1:0]    rx_req_valid_o;
  logic [NRX*AW-1:0] rx_req_addr_o;
  logic [NRX*DW-1:0] rx_data_i;
  logic [NRX-1:0]    rx_success_i;
  logic              alu_valid_o;
  logic [OW-1:0]     alu_opc_o;
  logic [NRX*DW-1:0] alu_operands_o;
  logic              alu_done_i;
  logic [DW-1:0]     alu_result_i;
  logic              icon_tx_req_valid_i;
  logic [AW-1:0]     icon_tx_addr_i;
  logic [DW-1:0]     icon_tx_data_o;
  logic              icon_tx_success_o;

  eu_operand_collector #(.NUM_RX(NRX), .DATA_W(DW), .ADDR_W(AW), .OPC_W(OW), .RES_DEPTH(RD)) dut (
    .clk(clk), .reset(reset),
    .instr_valid_i(instr_valid_i), .instr_opc_i(instr_opc_i),
    .instr_src_addr_i(instr_src_addr_i), .instr_dst_addr_i(instr_dst_addr_i),
    .ready_for_next_instr_o(ready_for_next_instr_o),
    .rx_req_valid_o(rx_req_valid_o), .rx_req_addr_o(rx_req_addr_o),
    .rx_data_i(rx_data_i), .rx_success_i(rx_success_i),
    .alu_valid_o(alu_valid_o), .alu_opc_o(alu_opc_o), .alu_operands_o(alu_operands_o),
    .alu_done_i(alu_done_i), .alu_result_i(alu_result_i),
    .icon_tx_req_valid_i(icon_tx_req_valid_i), .icon_tx_addr_i(icon_tx_addr_i),
    .icon_tx_data_o(icon_tx_data_o), .icon_tx_success_o(icon_tx_success_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic              rdy;
    logic [NRX-1:0]    rq;
    logic [NRX*AW-1:0] ra;
    logic              av;
  } cyc_t;
  typedef struct packed {
    logic [OW-1:0]     opc;
    logic [NRX*DW-1:0] ops;
  } alu_t;
  typedef struct packed {
    logic          succ;
    logic [DW-1:0] data;
  } tx_t;

  cyc_t cyc_q[$];
  alu_t alu_q[$];
  tx_t  tx_q[$];

  int total = 0;
  int bad   = 0;
  bit mon_en = 1'b0;

  // Reference model: result buffer as plain arrays plus the in-flight instruction's progress.
  bit            m_v [RD];
  logic [AW-1:0] m_a [RD];
  logic [DW-1:0] m_d [RD];
  bit            busy, fetching, executing, writing;
  bit [NRX-1:0]  need;
  logic [OW-1:0] cur_opc;
  logic [AW-1:0] cur_src [NRX];
  logic [DW-1:0] cur_ops [NRX];
  logic [AW-1:0] cur_dst;
  logic [DW-1:0] cur_res;
  bit            p_reset, p_accept, p_done, p_hit;
  bit [NRX-1:0]  p_succ;
  int            p_hit_idx;
  int            n_resets = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic do_cycle(input bit do_reset, input int txprob);
    cyc_t c;
    alu_t a;
    tx_t  t;
    int   ws;
    logic [DW-1:0] d;
    @(posedge clk);
    #1;
    // Fold the edge that just happened into the model.
    if (p_reset) begin
      for (int i = 0; i < RD; i++) m_v[i] = 1'b0;
      busy = 1'b0; fetching = 1'b0; executing = 1'b0; writing = 1'b0; need = '0;
      alu_q.delete();
    end else begin
      ws = 0;
      for (int i = RD - 1; i >= 0; i--) if (!m_v[i]) ws = i;
      if (p_hit) m_v[p_hit_idx] = 1'b0;
      if (writing) begin
        m_v[ws] = 1'b1; m_a[ws] = cur_dst; m_d[ws] = cur_res;
        writing = 1'b0; busy = 1'b0;
      end else if (executing) begin
        if (p_done) begin executing = 1'b0; writing = 1'b1; end
      end else if (fetching) begin
        need = need & ~p_succ;
        if (need == '0) begin
          fetching = 1'b0; executing = 1'b1;
          a.opc = cur_opc;
          for (int i = 0; i < NRX; i++) a.ops[i*DW +: DW] = cur_ops[i];
          alu_q.push_back(a);
        end
      end else if (p_accept) begin
        busy = 1'b1; fetching = 1'b1;
        for (int i = 0; i < NRX; i++) need[i] = (cur_src[i] != '0);
      end
    end

    reset = do_reset;
    c.rdy = !busy && !(m_v[0] && m_v[1] && m_v[2] && m_v[3]);
    c.rq  = fetching ? need : '0;
    c.ra  = '0;
    for (int i = 0; i < NRX; i++) if (c.rq[i]) c.ra[i*AW +: AW] = cur_src[i];
    c.av  = executing;
    cyc_q.push_back(c);

    instr_valid_i = 1'b0;
    if (!busy) begin
      cur_opc = OW'($urandom_range(0, 15));
      cur_dst = AW'($urandom_range(1, 6));
      for (int i = 0; i < NRX; i++) begin
        cur_src[i] = ($urandom_range(0, 3) == 0) ? '0 : AW'($urandom_range(1, 255));
        cur_ops[i] = '0;
        instr_src_addr_i[i*AW +: AW] = cur_src[i];
      end
      instr_opc_i      = cur_opc;
      instr_dst_addr_i = cur_dst;
      instr_valid_i    = ($urandom_range(0, 2) == 0);
    end
    p_accept = instr_valid_i && c.rdy;

    for (int i = 0; i < NRX; i++) begin
      d = DW'($urandom);
      rx_data_i[i*DW +: DW] = d;
      if (fetching && need[i]) begin
        rx_success_i[i] = ($urandom_range(0, 2) == 0);
        if (rx_success_i[i]) cur_ops[i] = d;
      end else begin
        rx_success_i[i] = ($urandom_range(0, 3) == 0);
      end
    end
    p_succ = rx_success_i;

    alu_done_i   = executing && ($urandom_range(0, 1) == 1);
    alu_result_i = DW'($urandom);
    if (alu_done_i) cur_res = alu_result_i;
    p_done = alu_done_i;

    icon_tx_req_valid_i = ($urandom_range(0, 99) < txprob);
    icon_tx_addr_i      = AW'($urandom_range(1, 6));
    p_hit = 1'b0; p_hit_idx = 0;
    for (int i = RD - 1; i >= 0; i--) begin
      if (m_v[i] && m_a[i] == icon_tx_addr_i) begin p_hit = icon_tx_req_valid_i; p_hit_idx = i; end
    end
    if (icon_tx_req_valid_i) begin
      t.succ = p_hit;
      t.data = p_hit ? m_d[p_hit_idx] : '0;
      tx_q.push_back(t);
    end
    p_reset = do_reset;
    mon_en  = 1'b1;
  endtask

  // Monitor: pops one expectation per presented output and compares.
  always @(negedge clk) begin
    cyc_t c;
    alu_t a;
    tx_t  t;
    if (mon_en) begin
      if (cyc_q.size() == 0) begin
        total++; bad++; $display("FAIL cyc_q: no expectation queued at %0t", $time);
      end else begin
        c = cyc_q.pop_front();
        chk("ready", 64'(ready_for_next_instr_o), 64'(c.rdy));
        chk("rx_req_valid", 64'(rx_req_valid_o), 64'(c.rq));
        chk("rx_req_addr", 64'(rx_req_addr_o), 64'(c.ra));
        chk("alu_valid", 64'(alu_valid_o), 64'(c.av));
      end
      if (alu_valid_o && alu_done_i) begin
        if (alu_q.size() == 0) begin
          total++; bad++; $display("FAIL alu: unexpected ALU handshake at %0t", $time);
        end else begin
          a = alu_q.pop_front();
          chk("alu_opc", 64'(alu_opc_o), 64'(a.opc));
          chk("alu_operands", 64'(alu_operands_o), 64'(a.ops));
        end
      end
      if (icon_tx_req_valid_i) begin
        if (tx_q.size() == 0) begin
          total++; bad++; $display("FAIL tx: no expectation queued at %0t", $time);
        end else begin
          t = tx_q.pop_front();
          chk("tx_success", 64'(icon_tx_success_o), 64'(t.succ));
          chk("tx_data", 64'(icon_tx_data_o), 64'(t.data));
        end
      end
    end
  end

  initial begin
    int  txprob;
    bit  rst_now;
    reset = 1'b1;
    instr_valid_i = 1'b0; instr_opc_i = '0; instr_src_addr_i = '0; instr_dst_addr_i = '0;
    rx_data_i = '0; rx_success_i = '0; alu_done_i = 1'b0; alu_result_i = '0;
    icon_tx_req_valid_i = 1'b0; icon_tx_addr_i = '0;
    busy = 1'b0; fetching = 1'b0; executing = 1'b0; writing = 1'b0; need = '0;
    p_reset = 1'b1; p_accept = 1'b0; p_done = 1'b0; p_hit = 1'b0; p_succ = '0; p_hit_idx = 0;
    for (int i = 0; i < RD; i++) begin m_v[i] = 1'b0; m_a[i] = '0; m_d[i] = '0; end
    cur_opc = '0; cur_dst = '0; cur_res = '0;
    for (int i = 0; i < NRX; i++) begin cur_src[i] = '0; cur_ops[i] = '0; end
    repeat (2) @(posedge clk);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      txprob  = (cyc < 800) ? 8 : ((cyc < 1600) ? 60 : 30);
      // Reset mid-FETCH with exactly one channel still outstanding.
      rst_now = (cyc >= 1000 + 700 * n_resets) && (n_resets < 2) && fetching && (need == 2'b01 || need == 2'b10);
      if (rst_now) n_resets++;
      do_cycle(rst_now, txprob);
    end
    do_cycle(1'b0, 0);
    @(negedge clk);
    #1;
    if (n_resets == 0) begin
      total++; bad++; $display("FAIL reset_mid_fetch: got 0 resets expected >=1");
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
